// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and window helper for the VGA pipeline.
// Border/playfield decoders import this instead of carrying local copies.
package vga_timing_pkg;

    localparam int POS_W    = 11;
    localparam int WIN_W    = POS_W + 1;
    localparam int COLOUR_W = 5;
    localparam logic [COLOUR_W-1:0] COLOUR_BLANK = '0;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_TOTAL   = 800;
    localparam int DEF_H_PULSE   = 96;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_V_TOTAL   = 521;
    localparam int DEF_V_PULSE   = 2;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_DISPLAY = 480;

    // Window bounds are widened by one bit so lo+len never wraps at TOTAL=2048.
    function automatic logic in_window(input logic [POS_W-1:0] pos,
                                       input int unsigned lo,
                                       input int unsigned len);
        logic [WIN_W-1:0] p;
        p = {1'b0, pos};
        return (p >= WIN_W'(lo)) && (p < WIN_W'(lo + len));
    endfunction

endpackage

// File: rtl/vga_sync_gen_pix_tick_div.sv
// Pixel-rate divider: one-clk pix_tick every CLK_DIV system clocks.
// The tick is registered so it stays low in reset even when CLK_DIV=1.
module pix_tick_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_next;
    logic          r_tick;

    assign w_div_next = (r_div == LAST) ? '0 : r_div + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_next;
            r_tick <= (w_div_next == LAST);
        end
    end

    assign pix_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters plus output-alignment stage: sync, video_on and colour
// are registered together so every pin toward the DAC moves on the same edge.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV     = DEF_CLK_DIV,
    parameter int   H_TOTAL     = DEF_H_TOTAL,
    parameter int   H_PULSE     = DEF_H_PULSE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_DISPLAY   = DEF_H_DISPLAY,
    parameter int   V_TOTAL     = DEF_V_TOTAL,
    parameter int   V_PULSE     = DEF_V_PULSE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_DISPLAY   = DEF_V_DISPLAY,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                pix_tick,
    output logic [POS_W-1:0]    hpos,
    output logic [POS_W-1:0]    vpos,
    input  logic [COLOUR_W-1:0] couleur_in,
    output logic [COLOUR_W-1:0] couleur_out,
    output logic                video_on,
    output logic                hsync,
    output logic                vsync,
    output logic                frame_start
);

    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_SYNC = POS_W'(H_PULSE);
    localparam logic [POS_W-1:0] V_SYNC = POS_W'(V_PULSE);

    logic                w_tick;
    logic                w_vis;
    logic                w_h_wrap;
    logic [POS_W-1:0]    r_hpos;
    logic [POS_W-1:0]    r_vpos;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_video_on;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_frame_start;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (w_tick)
    );

    assign w_h_wrap = (r_hpos == H_LAST);
    assign w_vis    = in_window(r_hpos, H_PULSE + H_FRONT, H_DISPLAY)
                   && in_window(r_vpos, V_PULSE + V_FRONT, V_DISPLAY);

    // Output stage samples the current position, giving one pixel of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_colour      <= COLOUR_BLANK;
            r_video_on    <= 1'b0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_tick) begin
                if (w_h_wrap) begin
                    r_hpos <= '0;
                    r_vpos <= (r_vpos == V_LAST) ? '0 : r_vpos + 1'b1;
                end else begin
                    r_hpos <= r_hpos + 1'b1;
                end
                r_hsync       <= (r_hpos < H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_vsync       <= (r_vpos < V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_video_on    <= w_vis;
                r_colour      <= w_vis ? couleur_in : COLOUR_BLANK;
                r_frame_start <= w_h_wrap && (r_vpos == V_LAST);
            end
        end
    end

    assign pix_tick    = w_tick;
    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign couleur_out = r_colour;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance plus two shrunk rasters
// (20x10 pixels, CLK_DIV 4 and 1) so full frames fit in a short run.
module tb_vga_sync_gen;

    localparam int SH_TOT = 20, SH_PUL = 3, SH_FR = 2, SH_DIS = 12;
    localparam int SV_TOT = 10, SV_PUL = 2, SV_FR = 1, SV_DIS = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  cin_def = '0, cin_a = '0, cin_b = '0;

    logic        tick_def, tick_a, tick_b;
    logic [10:0] hpos_def, vpos_def, hpos_a, vpos_a, hpos_b, vpos_b;
    logic [4:0]  cout_def, cout_a, cout_b;
    logic        vid_def, vid_a, vid_b;
    logic        hs_def, hs_a, hs_b, vs_def, vs_a, vs_b;
    logic        fs_def, fs_a, fs_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_def (
        .clk(clk), .rst(rst), .pix_tick(tick_def), .hpos(hpos_def), .vpos(vpos_def),
        .couleur_in(cin_def), .couleur_out(cout_def), .video_on(vid_def),
        .hsync(hs_def), .vsync(vs_def), .frame_start(fs_def)
    );

    vga_sync_gen #(
        .CLK_DIV(4), .H_TOTAL(SH_TOT), .H_PULSE(SH_PUL), .H_FRONT(SH_FR), .H_DISPLAY(SH_DIS),
        .V_TOTAL(SV_TOT), .V_PULSE(SV_PUL), .V_FRONT(SV_FR), .V_DISPLAY(SV_DIS), .SYNC_ACTIVE(1'b0)
    ) u_a (
        .clk(clk), .rst(rst), .pix_tick(tick_a), .hpos(hpos_a), .vpos(vpos_a),
        .couleur_in(cin_a), .couleur_out(cout_a), .video_on(vid_a),
        .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_TOTAL(SH_TOT), .H_PULSE(SH_PUL), .H_FRONT(SH_FR), .H_DISPLAY(SH_DIS),
        .V_TOTAL(SV_TOT), .V_PULSE(SV_PUL), .V_FRONT(SV_FR), .V_DISPLAY(SV_DIS), .SYNC_ACTIVE(1'b0)
    ) u_b (
        .clk(clk), .rst(rst), .pix_tick(tick_b), .hpos(hpos_b), .vpos(vpos_b),
        .couleur_in(cin_b), .couleur_out(cout_b), .video_on(vid_b),
        .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    typedef struct {
        int         h;
        int         v;
        logic [4:0] cin;
        logic       hs;
        logic       vs;
        logic       vid;
        logic [4:0] cout;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Stops at the negedge where u_a's pix_tick is high at position (h,v).
    task automatic wait_tick_a(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (tick_a && hpos_a == 11'(h) && vpos_a == 11'(v)) ok = 1'b1;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " def pos/tick"}, {tick_def, vpos_def, hpos_def}, 32'd0);
        chk({tag, " def outs"}, {fs_def, hs_def, vs_def, vid_def, cout_def}, {1'b0, 1'b1, 1'b1, 1'b0, 5'd0});
        chk({tag, " a pos/tick"}, {tick_a, vpos_a, hpos_a}, 32'd0);
        chk({tag, " a outs"}, {fs_a, hs_a, vs_a, vid_a, cout_a}, {1'b0, 1'b1, 1'b1, 1'b0, 5'd0});
        chk({tag, " b pos/tick"}, {tick_b, vpos_b, hpos_b}, 32'd0);
        chk({tag, " b outs"}, {fs_b, hs_b, vs_b, vid_b, cout_b}, {1'b0, 1'b1, 1'b1, 1'b0, 5'd0});
    endtask

    initial begin
        bit ok;
        int hs_lo, vs_lo, vid_cnt, c8_cnt, bad_col, tick_cnt, fs_idx, fs_cnt;
        logic [21:0] first_vis, last_vis, first_hs;
        bit got_first, got_hs;

        vecs[0]  = '{h: 0,  v: 0, cin: 5'd8,  hs: 1'b0, vs: 1'b0, vid: 1'b0, cout: 5'd0};
        vecs[1]  = '{h: 2,  v: 0, cin: 5'd8,  hs: 1'b0, vs: 1'b0, vid: 1'b0, cout: 5'd0};
        vecs[2]  = '{h: 3,  v: 1, cin: 5'd8,  hs: 1'b1, vs: 1'b0, vid: 1'b0, cout: 5'd0};
        vecs[3]  = '{h: 5,  v: 2, cin: 5'd8,  hs: 1'b1, vs: 1'b1, vid: 1'b0, cout: 5'd0};
        vecs[4]  = '{h: 4,  v: 3, cin: 5'd8,  hs: 1'b1, vs: 1'b1, vid: 1'b0, cout: 5'd0};
        vecs[5]  = '{h: 5,  v: 3, cin: 5'd8,  hs: 1'b1, vs: 1'b1, vid: 1'b1, cout: 5'd8};
        vecs[6]  = '{h: 16, v: 3, cin: 5'd21, hs: 1'b1, vs: 1'b1, vid: 1'b1, cout: 5'd21};
        vecs[7]  = '{h: 17, v: 3, cin: 5'd21, hs: 1'b1, vs: 1'b1, vid: 1'b0, cout: 5'd0};
        vecs[8]  = '{h: 0,  v: 4, cin: 5'd12, hs: 1'b0, vs: 1'b1, vid: 1'b0, cout: 5'd0};
        vecs[9]  = '{h: 10, v: 8, cin: 5'd31, hs: 1'b1, vs: 1'b1, vid: 1'b1, cout: 5'd31};
        vecs[10] = '{h: 10, v: 9, cin: 5'd31, hs: 1'b1, vs: 1'b1, vid: 1'b0, cout: 5'd0};
        vecs[11] = '{h: 19, v: 9, cin: 5'd7,  hs: 1'b1, vs: 1'b1, vid: 1'b0, cout: 5'd0};

        // Asynchronous reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1 check_reset("por");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Default instance: run to hpos=300 on line 0, then reset mid-line.
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (hpos_def == 11'd300) ok = 1'b1;
        end
        chk("def reach hpos300", 32'(ok), 32'd1);
        chk("def outs at hpos300", {hs_def, vs_def, vid_def, cout_def}, {1'b1, 1'b0, 1'b0, 5'd0});
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset("midline");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Divider restart: tick on every 4th clk (a) / every clk (b), hpos steps only on ticks.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("a step k=%0d", k), {tick_a, hpos_a}, {((k % 4) == 3), 11'(k / 4)});
            chk($sformatf("b step k=%0d", k), {tick_b, hpos_b}, {1'b1, 11'(k - 1)});
        end

        // Table-driven raster checks on u_a: outputs one pixel after (h,v).
        for (int i = 0; i < 12; i++) begin
            cin_a = vecs[i].cin;
            wait_tick_a(vecs[i].h, vecs[i].v, ok);
            if (!ok) begin
                chk($sformatf("vec%0d reach", i), 32'd0, 32'd1);
            end else begin
                @(negedge clk);
                chk($sformatf("vec%0d h=%0d v=%0d", i, vecs[i].h, vecs[i].v),
                    {hs_a, vs_a, vid_a, cout_a},
                    {vecs[i].hs, vecs[i].vs, vecs[i].vid, vecs[i].cout});
            end
        end

        // Line wrap then frame wrap on u_a.
        wait_tick_a(19, 4, ok);
        @(negedge clk);
        chk("a line wrap", {32'(ok), vpos_a, hpos_a}, {32'd1, 11'd5, 11'd0});
        wait_tick_a(19, 9, ok);
        @(negedge clk);
        chk("a frame wrap", {32'(ok), fs_a, vpos_a, hpos_a}, {32'd1, 1'b1, 11'd0, 11'd0});
        @(negedge clk);
        chk("a frame_start one clk", 32'(fs_a), 32'd0);

        // Full-frame statistics on u_b (CLK_DIV=1, one pixel per clk).
        cin_b = 5'd8;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (fs_b) ok = 1'b1;
        end
        chk("b frame_start seen", 32'(ok), 32'd1);
        chk("b frame_start pos", {vpos_b, hpos_b}, 22'd0);
        hs_lo = 0; vs_lo = 0; vid_cnt = 0; c8_cnt = 0; bad_col = 0; tick_cnt = 0;
        fs_idx = -1; fs_cnt = 0; got_first = 1'b0; got_hs = 1'b0;
        first_vis = '1; last_vis = '1; first_hs = '1;
        for (int i = 0; i <= 200; i++) begin
            if (i > 0 && fs_b && fs_idx < 0) fs_idx = i;
            if (i < 200) begin
                if (fs_b) fs_cnt++;
                if (!hs_b) hs_lo++;
                if (!vs_b) vs_lo++;
                if (vid_b) vid_cnt++;
                if (tick_b) tick_cnt++;
                if (cout_b == 5'd8) begin
                    c8_cnt++;
                    if (!got_first) first_vis = {vpos_b, hpos_b};
                    got_first = 1'b1;
                    last_vis = {vpos_b, hpos_b};
                end else if (cout_b != 5'd0) begin
                    bad_col++;
                end
                if (!hs_b && !got_hs) begin
                    first_hs = {vpos_b, hpos_b};
                    got_hs = 1'b1;
                end
            end
            if (i < 200) @(negedge clk);
        end
        chk("b frame period", 32'(fs_idx), 32'd200);
        chk("b frame_start count", 32'(fs_cnt), 32'd1);
        chk("b pix_tick constant", 32'(tick_cnt), 32'd200);
        chk("b hsync low ticks", 32'(hs_lo), 32'(SH_PUL * SV_TOT));
        chk("b vsync low ticks", 32'(vs_lo), 32'(SV_PUL * SH_TOT));
        chk("b video_on ticks", 32'(vid_cnt), 32'(SH_DIS * SV_DIS));
        chk("b colour8 ticks", 32'(c8_cnt), 32'(SH_DIS * SV_DIS));
        chk("b stray colour", 32'(bad_col), 32'd0);
        chk("b first visible", first_vis, {11'd3, 11'd6});
        chk("b last visible", last_vis, {11'd8, 11'd17});
        chk("b first hsync low", first_hs, {11'd0, 11'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
